// File: rtl/rx_serial_8n1_if.sv
// Port bundle for the 8N1 receiver: serial line in, received byte and status out.
interface rx_serial_8n1_if;
    logic       rx;
    logic [7:0] rx_dados;
    logic       rx_pronto;
    logic       erro_quadro;
    logic       ocupado;

    modport master (output rx, input  rx_dados, rx_pronto, erro_quadro, ocupado);
    modport slave  (input  rx, output rx_dados, rx_pronto, erro_quadro, ocupado);
endinterface

// File: rtl/rx_serial_8n1.sv
// 8N1 UART receiver: 2-flop line synchronizer, mid-bit sampling FSM and a
// registered byte output with one-cycle ready / framing-error pulses.
module rx_serial_8n1 #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic           i_clk,
    input  logic           i_rst,
    rx_serial_8n1_if.slave bus
);
    localparam int            CW       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic          r_sync1, r_sync2;
    logic          w_rx_s;
    state_t        r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [2:0]    r_bit, w_bit;
    logic [7:0]    r_shift, w_shift;
    logic [7:0]    r_dados, w_dados;
    logic          r_pronto, w_pronto;
    logic          r_erro, w_erro;

    // NOTE: the synchronizer resets to the idle line level, so leaving reset never fakes a start bit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    // NOTE: every register here updates with <= so all of them see the same pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= 8'h00;
            r_dados  <= 8'h00;
            r_pronto <= 1'b0;
            r_erro   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_bit    <= w_bit;
            r_shift  <= w_shift;
            r_dados  <= w_dados;
            r_pronto <= w_pronto;
            r_erro   <= w_erro;
        end
    end

    // NOTE: each next-value gets a default before the case, so no path can infer a latch.
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_bit    = r_bit;
        w_shift  = r_shift;
        w_dados  = r_dados;
        w_pronto = 1'b0;
        w_erro   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state = S_START;
                    w_cnt   = '0;
                end
            end
            S_START: begin
                // Half-bit check: a start bit that has gone high again was a glitch.
                if (r_cnt == CNT_HALF) begin
                    w_cnt   = '0;
                    w_bit   = '0;
                    w_state = w_rx_s ? S_IDLE : S_DATA;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt          = '0;
                    w_shift[r_bit] = w_rx_s;
                    if (r_bit == 3'd7) begin
                        w_state = S_STOP;
                    end else begin
                        w_bit = r_bit + 1'b1;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt = '0;
                    if (w_rx_s) begin
                        w_dados  = r_shift;
                        w_pronto = 1'b1;
                        w_state  = S_IDLE;
                    end else begin
                        w_erro  = 1'b1;
                        w_state = S_WAIT_IDLE;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (w_rx_s) begin
                    w_state = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign bus.rx_dados    = r_dados;
    assign bus.rx_pronto   = r_pronto;
    assign bus.erro_quadro = r_erro;
    assign bus.ocupado     = (r_state != S_IDLE);
endmodule

// File: tb/tb_rx_serial_8n1.sv
// Directed and random 8N1 frames against a frame-level scoreboard of expected
// bytes, latency windows and framing-error counts.
module tb_rx_serial_8n1;
    localparam int C       = 8;
    localparam int H       = C / 2;
    localparam int LAT_MIN = 9 * C + H;

    typedef struct {
        logic [7:0] data;
        int         t0;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rx_serial_8n1_if bus ();

    rx_serial_8n1 #(.CLKS_PER_BIT(C)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    exp_t       exp_q[$];
    int         pronto_cnt = 0;
    int         erro_cnt = 0;
    int         exp_erro = 0;
    int         exp_pronto = 0;
    logic [7:0] model_dados = 8'h00;
    logic       prev_pronto = 1'b0;
    logic       prev_erro = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Continuous monitor: pulse exclusivity/width, scoreboard of good frames.
    always @(negedge clk) begin : mon
        exp_t e;
        int   lat;
        check("pronto_and_erro", 32'(bus.rx_pronto & bus.erro_quadro), 32'd0);
        if (bus.rx_pronto === 1'b1) begin
            pronto_cnt++;
            check("pronto_width", 32'(prev_pronto), 32'd0);
            check("pronto_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                lat = cyc - e.t0;
                check("pronto_byte", 32'(bus.rx_dados), 32'(e.data));
                check("pronto_latency", 32'(lat >= LAT_MIN && lat <= LAT_MIN + 4), 32'd1);
            end
        end
        if (bus.erro_quadro === 1'b1) begin
            erro_cnt++;
            check("erro_width", 32'(prev_erro), 32'd0);
        end
        prev_pronto = bus.rx_pronto;
        prev_erro   = bus.erro_quadro;
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic drive_bit(input logic b);
        bus.rx = b;
        repeat (C) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        if (stop_ok) begin
            exp_q.push_back('{data: d, t0: cyc + 1});
            exp_pronto++;
            model_dados = d;
        end else begin
            exp_erro++;
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_ok);
    endtask

    task automatic idle(input int n);
        bus.rx = 1'b1;
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_dados"}, 32'(bus.rx_dados), 32'd0);
        check({tag, "_pronto"}, 32'(bus.rx_pronto), 32'd0);
        check({tag, "_erro"}, 32'(bus.erro_quadro), 32'd0);
        check({tag, "_ocupado"}, 32'(bus.ocupado), 32'd0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [7:0] d;
        logic       ok;
        int         occ;
        int         base_p;

        bus.rx = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);

        // Single clean byte
        send_frame(8'hA5, 1'b1);
        idle(4);
        check("a5_dados", 32'(bus.rx_dados), 32'h A5);
        check("a5_count", 32'(pronto_cnt), 32'(exp_pronto));
        check("a5_erro", 32'(erro_cnt), 32'd0);
        check("a5_drained", 32'(exp_q.size()), 32'd0);

        // Back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(4);
        check("b2b_count", 32'(pronto_cnt), 32'(exp_pronto));
        check("b2b_dados", 32'(bus.rx_dados), 32'h FF);
        check("b2b_drained", 32'(exp_q.size()), 32'd0);

        // Random bytes, random gaps, occasional bad stop bit
        for (int n = 0; n < 16; n++) begin
            d  = 8'($urandom);
            ok = ($urandom_range(3) != 0);
            send_frame(d, ok);
            idle(ok ? int'($urandom_range(4)) : 3 + int'($urandom_range(3)));
        end
        idle(4);
        check("rand_count", 32'(pronto_cnt), 32'(exp_pronto));
        check("rand_erro", 32'(erro_cnt), 32'(exp_erro));
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        check("rand_hold_dados", 32'(bus.rx_dados), 32'(model_dados));

        // Two-cycle glitch from idle
        base_p = pronto_cnt;
        occ    = 0;
        bus.rx = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.rx = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.ocupado === 1'b1) occ++;
        end
        check("glitch_busy_cycles", 32'(occ >= 1 && occ <= 6), 32'd1);
        check("glitch_ocupado_end", 32'(bus.ocupado), 32'd0);
        check("glitch_no_pronto", 32'(pronto_cnt), 32'(base_p));
        check("glitch_no_erro", 32'(erro_cnt), 32'(exp_erro));
        @(posedge clk);
        #1;

        // Framing error followed by a 40-cycle break
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b0);
        bus.rx = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("break_erro_once", 32'(erro_cnt), 32'(exp_erro));
        check("break_no_pronto", 32'(pronto_cnt), 32'(exp_pronto));
        check("break_dados", 32'(bus.rx_dados), 32'h A5);
        check("break_still_busy", 32'(bus.ocupado), 32'd1);
        idle(4);
        check("break_back_idle", 32'(bus.ocupado), 32'd0);
        check("break_erro_final", 32'(erro_cnt), 32'(exp_erro));

        // Reset after four data bits of a frame
        base_p = pronto_cnt;
        d      = 8'hC3;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        #3;
        rst    = 1'b1;
        bus.rx = 1'b1;
        #1;
        check_outputs_zero("midreset");
        repeat (3) @(posedge clk);
        #1;
        rst         = 1'b0;
        model_dados = 8'h00;
        idle(4);
        check("postreset_idle", 32'(bus.ocupado), 32'd0);
        check("postreset_no_pronto", 32'(pronto_cnt), 32'(base_p));
        send_frame(8'h5A, 1'b1);
        idle(4);
        check("postreset_dados", 32'(bus.rx_dados), 32'h 5A);
        check("postreset_count", 32'(pronto_cnt), 32'(base_p + 1));
        check("postreset_erro", 32'(erro_cnt), 32'(exp_erro));
        check("postreset_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rx_serial_8n1.md
RX_SERIAL_8N1 -- requirements
Module: rx_serial_8n1

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200 baud); legal values are integers >= 4.
REQ-002 clock  in  1  single system clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 rx  in  1  asynchronous serial line, 8N1, LSB first, idles high.
REQ-005 rx_dados  out  8  last correctly framed byte; feeds rx_dados of the Sobel processing unit.
REQ-006 rx_pronto  out  1  one-cycle pulse: new byte valid on rx_dados; feeds rx_pronto of the Sobel processing unit.
REQ-007 erro_quadro  out  1  one-cycle pulse: stop bit sampled low.
REQ-008 ocupado  out  1  high while a frame is in progress (state != IDLE).

Function
REQ-009 rx SHALL pass through a 2-flop synchronizer; the FSM SHALL use only the second flop's output (rx_s).
REQ-010 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_IDLE; bit counter 3 bits; cycle counter wide enough for CLKS_PER_BIT-1.
REQ-011 IDLE: on rx_s == 0 go to START with cycle counter cleared; otherwise remain.
REQ-012 START: at cycle counter == CLKS_PER_BIT/2 - 1 (integer division) sample rx_s; 0 -> DATA, counter and bit index cleared; 1 -> IDLE (glitch rejected, no output pulse).
REQ-013 DATA: sample rx_s each time the counter reaches CLKS_PER_BIT-1, then clear the counter; the sample goes into shift-register bit [bit index], LSB first; after the 8th sample go to STOP.
REQ-014 STOP: sample rx_s when the counter reaches CLKS_PER_BIT-1.
REQ-015 Stop sample 1: load the shift register into rx_dados, pulse rx_pronto for exactly one cycle, go to IDLE.
REQ-016 Stop sample 0: pulse erro_quadro for exactly one cycle, leave rx_dados unchanged, no rx_pronto, go to WAIT_IDLE.
REQ-017 WAIT_IDLE: remain until rx_s == 1, then go to IDLE; a line held low (break) SHALL produce exactly one erro_quadro.
REQ-018 rx_pronto and erro_quadro SHALL never be high in the same cycle.
REQ-019 Latency: let t0 be the first clock edge that registers rx == 0 at the synchronizer input. rx_pronto SHALL be high in one cycle within [t0 + 9*CLKS_PER_BIT + CLKS_PER_BIT/2, that value + 4].
REQ-020 rx_dados SHALL hold its value between pulses; the downstream block MAY read it at any time after rx_pronto.
REQ-021 Back-to-back frames (new start bit immediately after the stop bit) SHALL be received with no lost byte.
REQ-022 ocupado SHALL be 0 exactly when the state is IDLE.
REQ-023 There is no backpressure: a byte not consumed before the next rx_pronto is overwritten.

Reset
REQ-024 While reset is high, these SHALL apply asynchronously: state = IDLE; all counters = 0; shift register = 0x00; rx_dados = 0x00; rx_pronto = 0; erro_quadro = 0; ocupado = 0; both synchronizer flops = 1.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no pulse.
REQ-026 After reset is released, reception SHALL resume only on a fresh falling edge observed at rx_s.

Verification (CLKS_PER_BIT = 8)
REQ-027 Send 0xA5, 8N1 -> rx_dados = 0xA5; one-cycle rx_pronto inside the REQ-019 window; erro_quadro stays 0.
REQ-028 Send 0x00 then 0xFF with no idle gap -> two rx_pronto pulses, rx_dados 0x00 then 0xFF.
REQ-029 Drive rx low for 2 cycles from IDLE -> no pulses; ocupado high for at most 6 cycles, then back to 0.
REQ-030 After 0xA5, send 0x3C with stop bit 0 and hold rx low 40 cycles -> exactly one erro_quadro pulse; rx_dados stays 0xA5; no rx_pronto; state returns to IDLE only after rx returns high.
REQ-031 Assert reset after 4 data bits of a frame -> all outputs 0 immediately; no pulse; a subsequent clean 0x5A frame yields rx_dados = 0x5A with one rx_pronto.
REQ-032 Check continuously: no cycle with rx_pronto & erro_quadro; every pulse exactly one cycle wide.
